// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU sequencer: phase bus codes,
// instruction class codes, the "always" condition and the compare-opcode range.
package cpu_pkg;

    // Values driven on the shared phase bus
    typedef enum logic [1:0] {
        PH_FETCH  = 2'b00,
        PH_DECODE = 2'b01,
        PH_EXEC   = 2'b10,
        PH_WB     = 2'b11
    } phase_e;

    // Instruction class held in ir[27:26]
    typedef enum logic [1:0] {
        CLS_DP  = 2'b00,
        CLS_LS  = 2'b01,
        CLS_BR  = 2'b10,
        CLS_UND = 2'b11
    } iclass_e;

    // Condition code presented when no instruction is in flight
    localparam logic [3:0] COND_AL = 4'b1110;

    // Data-processing opcodes in this range only update flags
    localparam logic [3:0] CMP_OP_LO = 4'b1000;
    localparam logic [3:0] CMP_OP_HI = 4'b1011;

endpackage

// File: rtl/phase_ctrl_if.sv
// Bus between the phase sequencer and the rest of the CPU: instruction fetch
// data, memory/flags feedback, the phase bus and the commit strobes.
interface phase_ctrl_if #(
    parameter int REG_SIZE = 32,
    parameter int COND_LEN = 4
);
    logic [REG_SIZE-1:0] instr;
    logic                mem_busy;
    logic                cond_met;
    logic                halt;
    logic [1:0]          phase;
    logic [REG_SIZE-1:0] ir;
    logic [COND_LEN-1:0] cond_code;
    logic                comp;
    logic                mem_re;
    logic                mem_we;
    logic                reg_we;
    logic                pc_we;
    logic                branch_take;
    logic                halted;

    modport master (
        input  instr, mem_busy, cond_met, halt,
        output phase, ir, cond_code, comp, mem_re, mem_we, reg_we, pc_we,
               branch_take, halted
    );

    modport slave (
        output instr, mem_busy, cond_met, halt,
        input  phase, ir, cond_code, comp, mem_re, mem_we, reg_we, pc_we,
               branch_take, halted
    );
endinterface

// File: rtl/instr_decode.sv
// Combinational field decode of the latched instruction word.
module instr_decode
    import cpu_pkg::*;
#(
    parameter int REG_SIZE = 32
) (
    input  logic [REG_SIZE-1:0] ir,
    output iclass_e             iclass,
    output logic                s_bit,
    output logic                l_bit,
    output logic                is_compare,
    output logic                writes_reg
);
    logic [3:0] opcode;
    logic       unused_fields;

    assign unused_fields = ^{ir[REG_SIZE-1:28], ir[25], ir[19:0]};

    // Class, S/L bits and register-write intent from the instruction fields
    always_comb begin
        iclass     = iclass_e'(ir[27:26]);
        opcode     = ir[24:21];
        s_bit      = ir[20];
        l_bit      = (iclass == CLS_LS) && ir[20];
        is_compare = (iclass == CLS_DP) && (opcode >= CMP_OP_LO) && (opcode <= CMP_OP_HI);
        writes_reg = ((iclass == CLS_DP) && !is_compare) || l_bit;
    end

endmodule

// File: rtl/phase_ctrl.sv
// Four-phase instruction sequencer (FETCH, DECODE, EXEC, WB).
// Optional debug halt parking state enabled by defining PHASE_CTRL_HALT_EN.
module phase_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_SIZE = 32,
    parameter int COND_LEN = 4
) (
    input logic          clk,
    input logic          rst_n,
    phase_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3
`ifdef PHASE_CTRL_HALT_EN
        , ST_HALT = 3'd4
`endif
    } state_e;

    state_e              state;
    state_e              next_state;
    logic [REG_SIZE-1:0] ir_q;

    iclass_e iclass;
    logic    s_bit;
    logic    l_bit;
    logic    is_compare;
    logic    writes_reg;
    logic    is_dp;
    logic    is_ls;
    logic    is_br;
    logic    exec_done;

    phase_e  phase_c;
    logic    comp_c;
    logic    mem_re_c;
    logic    mem_we_c;
    logic    reg_we_c;
    logic    pc_we_c;
    logic    branch_take_c;
    logic    halted_c;
    logic    in_instr;

    instr_decode #(.REG_SIZE(REG_SIZE)) u_decode (
        .ir         (ir_q),
        .iclass     (iclass),
        .s_bit      (s_bit),
        .l_bit      (l_bit),
        .is_compare (is_compare),
        .writes_reg (writes_reg)
    );

    assign is_dp = (iclass == CLS_DP);
    assign is_ls = (iclass == CLS_LS);
    assign is_br = (iclass == CLS_BR);

`ifndef PHASE_CTRL_HALT_EN
    logic unused_halt;
    assign unused_halt = bus.halt ^ is_compare;
`endif

    // Phase state register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Instruction latch, loaded on the edge leaving FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else if (state == ST_FETCH) begin
            ir_q <= bus.instr;
        end
    end

    // Next-state and strobe generation; stores commit only in WB so a failed
    // condition can never write memory
    always_comb begin
        next_state    = state;
        phase_c       = PH_FETCH;
        comp_c        = 1'b0;
        mem_re_c      = 1'b0;
        mem_we_c      = 1'b0;
        reg_we_c      = 1'b0;
        pc_we_c       = 1'b0;
        branch_take_c = 1'b0;
        halted_c      = 1'b0;
        exec_done     = !(is_ls && bus.mem_busy);
        case (state)
            ST_FETCH: begin
                phase_c    = PH_FETCH;
                next_state = ST_DECODE;
            end
            ST_DECODE: begin
                phase_c    = PH_DECODE;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                phase_c  = PH_EXEC;
                mem_re_c = is_ls && l_bit;
                comp_c   = exec_done && is_dp && s_bit;
                if (exec_done) begin
                    next_state = ST_WB;
                end
            end
            ST_WB: begin
                phase_c       = PH_WB;
                pc_we_c       = 1'b1;
                reg_we_c      = bus.cond_met && writes_reg;
                mem_we_c      = bus.cond_met && is_ls && !l_bit;
                branch_take_c = bus.cond_met && is_br;
`ifdef PHASE_CTRL_HALT_EN
                next_state    = bus.halt ? ST_HALT : ST_FETCH;
`else
                next_state    = ST_FETCH;
`endif
            end
`ifdef PHASE_CTRL_HALT_EN
            ST_HALT: begin
                phase_c    = PH_FETCH;
                halted_c   = 1'b1;
                next_state = bus.halt ? ST_HALT : ST_FETCH;
            end
`endif
            default: begin
                next_state = ST_FETCH;
            end
        endcase
    end

    assign in_instr = (state == ST_DECODE) || (state == ST_EXEC) || (state == ST_WB);

    assign bus.phase       = phase_c;
    assign bus.ir          = ir_q;
    assign bus.cond_code   = in_instr ? ir_q[REG_SIZE-1 -: COND_LEN] : COND_LEN'(COND_AL);
    assign bus.comp        = comp_c;
    assign bus.mem_re      = mem_re_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.reg_we      = reg_we_c;
    assign bus.pc_we       = pc_we_c;
    assign bus.branch_take = branch_take_c;
    assign bus.halted      = halted_c;

endmodule
